// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Brief   : Opcodes, flag indices, instruction fields and FSM types for the
//           ALU issue stage.
// Revision: 1.0
// ============================================================================
package alu_pkg;

    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_MUL  = 8'h02;
    localparam logic [7:0] OP_CMP  = 8'h03;
    localparam logic [7:0] OP_RSH  = 8'h04;
    localparam logic [7:0] OP_LSH  = 8'h05;
    localparam logic [7:0] OP_LDI  = 8'h06;
    localparam logic [7:0] OP_HALT = 8'hFF;

    localparam int FL_CARRY = 0;
    localparam int FL_OVF   = 1;
    localparam int FL_NEG   = 2;
    localparam int FL_ZERO  = 3;

    localparam int INSTR_W = 24;
    localparam int OPC_LSB = 16;
    localparam int RD_LSB  = 14;
    localparam int RS1_LSB = 12;
    localparam int RS2_LSB = 10;
    localparam int IMM_LSB = 0;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    // ADD and CMP are the only kinds whose ALU flags are architectural
    typedef enum logic [1:0] {
        KIND_ADD = 2'd0,
        KIND_CMP = 2'd1,
        KIND_ALU = 2'd2,
        KIND_LDI = 2'd3
    } ex_kind_t;

    function automatic logic kind_writes_rd(input ex_kind_t kind);
        return (kind != KIND_CMP);
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_issue_stage_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_issue_stage_if
// Brief   : Instruction valid/ready handshake into the issue stage.
// Revision: 1.0
// ============================================================================
interface alu_issue_stage_if;
    import alu_pkg::*;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;

    modport master (
        output instr_valid,
        output instr,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr,
        output instr_ready
    );

endinterface : alu_issue_stage_if
`default_nettype wire

// File: rtl/alu_issue_stage_regfile_4x8.sv
`default_nettype none
// ============================================================================
// Module  : regfile_4x8
// Brief   : 4-entry register file, two async read ports, one sync write port
//           and a debug read port.
// Revision: 1.0
// ============================================================================
module regfile_4x8 #(
    parameter int          DW     = 8,
    parameter logic [DW-1:0] RF_RST = '0
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic [1:0]    rd_addr_a,
    output logic      [DW-1:0] rd_data_a,
    input  wire logic [1:0]    rd_addr_b,
    output logic      [DW-1:0] rd_data_b,
    input  wire logic          we,
    input  wire logic [1:0]    wr_addr,
    input  wire logic [DW-1:0] wr_data,
    input  wire logic [1:0]    dbg_sel,
    output logic      [DW-1:0] dbg_data
);

    logic [DW-1:0] r_mem [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= RF_RST;
            end
        end else if (we) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = r_mem[rd_addr_a];
    assign rd_data_b = r_mem[rd_addr_b];
    assign dbg_data  = r_mem[dbg_sel];

endmodule : regfile_4x8
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module  : alu_issue_stage
// Brief   : Issue/writeback stage around an external combinational ALU, with
//           EX-to-issue forwarding, flags register and RUN/HALT control.
// Revision: 1.0
// ============================================================================
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int            DW     = 8,
    parameter logic [DW-1:0] RF_RST = 8'h00
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    alu_issue_stage_if.slave   instr_if,
    input  wire logic          go,
    output logic      [7:0]    alu_opcode,
    output logic      [DW-1:0] alu_op1,
    output logic      [DW-1:0] alu_op2,
    input  wire logic [DW-1:0] alu_dout,
    input  wire logic [7:0]    alu_eflags,
    output logic      [3:0]    flags,
    output logic               wb_valid,
    output logic      [1:0]    wb_rd,
    output logic      [DW-1:0] wb_data,
    output logic               illegal,
    input  wire logic [1:0]    dbg_sel,
    output logic      [DW-1:0] dbg_data
);

    state_t        r_state;
    logic [7:0]    r_alu_opcode;
    logic [DW-1:0] r_alu_op1;
    logic [DW-1:0] r_alu_op2;
    logic [3:0]    r_flags;
    logic          r_wb_valid;
    logic [1:0]    r_wb_rd;
    logic [DW-1:0] r_wb_data;
    logic          r_illegal;
    logic          r_ex_vld;
    logic [1:0]    r_ex_rd;
    logic [DW-1:0] r_ex_imm;
    ex_kind_t      r_ex_kind;

    logic [7:0]    w_opcode;
    logic [1:0]    w_rd;
    logic [1:0]    w_rs1;
    logic [1:0]    w_rs2;
    logic [7:0]    w_imm;
    logic          w_accept;
    logic          w_is_exec;
    logic          w_is_halt;
    logic          w_is_illegal;
    ex_kind_t      w_kind;
    logic [DW-1:0] w_rf_a;
    logic [DW-1:0] w_rf_b;
    logic [DW-1:0] w_op1;
    logic [DW-1:0] w_op2;
    logic [DW-1:0] w_ex_result;
    logic          w_ex_writes;
    logic          w_unused;

    assign w_opcode = instr_if.instr[OPC_LSB +: 8];
    assign w_rd     = instr_if.instr[RD_LSB  +: 2];
    assign w_rs1    = instr_if.instr[RS1_LSB +: 2];
    assign w_rs2    = instr_if.instr[RS2_LSB +: 2];
    assign w_imm    = instr_if.instr[IMM_LSB +: 8];
    assign w_unused = ^{instr_if.instr[9:8], alu_eflags[7:4]};

    assign instr_if.instr_ready = (r_state == RUN);
    assign w_accept = instr_if.instr_valid & instr_if.instr_ready;

    always_comb begin
        w_kind       = KIND_ALU;
        w_is_exec    = 1'b1;
        w_is_halt    = 1'b0;
        w_is_illegal = 1'b0;
        case (w_opcode)
            OP_ADD:                 w_kind = KIND_ADD;
            OP_CMP:                 w_kind = KIND_CMP;
            OP_MUL, OP_RSH, OP_LSH: w_kind = KIND_ALU;
            OP_LDI:                 w_kind = KIND_LDI;
            OP_HALT: begin
                w_is_exec = 1'b0;
                w_is_halt = 1'b1;
            end
            default: begin
                w_is_exec    = 1'b0;
                w_is_illegal = 1'b1;
            end
        endcase
    end

    // The EX result bypasses the register file while its write is in flight
    assign w_ex_result = (r_ex_kind == KIND_LDI) ? r_ex_imm : alu_dout;
    assign w_ex_writes = r_ex_vld & kind_writes_rd(r_ex_kind);
    assign w_op1 = (w_ex_writes && (w_rs1 == r_ex_rd)) ? w_ex_result : w_rf_a;
    assign w_op2 = (w_ex_writes && (w_rs2 == r_ex_rd)) ? w_ex_result : w_rf_b;

    regfile_4x8 #(
        .DW     (DW),
        .RF_RST (RF_RST)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (w_rs1),
        .rd_data_a (w_rf_a),
        .rd_addr_b (w_rs2),
        .rd_data_b (w_rf_b),
        .we        (w_ex_writes),
        .wr_addr   (r_ex_rd),
        .wr_data   (w_ex_result),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            case (r_state)
                RUN:     if (w_accept && w_is_halt) r_state <= HALT;
                HALT:    if (go) r_state <= RUN;
                default: r_state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_opcode <= '0;
            r_alu_op1    <= '0;
            r_alu_op2    <= '0;
            r_flags      <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_data    <= '0;
            r_illegal    <= 1'b0;
            r_ex_vld     <= 1'b0;
            r_ex_rd      <= '0;
            r_ex_imm     <= '0;
            r_ex_kind    <= KIND_ADD;
        end else begin
            r_ex_vld   <= 1'b0;
            r_illegal  <= 1'b0;
            r_wb_valid <= 1'b0;

            if (w_accept) begin
                r_alu_op1 <= w_op1;
                r_alu_op2 <= w_op2;
                r_ex_rd   <= w_rd;
                r_ex_imm  <= DW'(w_imm);
                r_ex_kind <= w_kind;
                r_ex_vld  <= w_is_exec;
                r_illegal <= w_is_illegal;
                r_alu_opcode <= (w_is_exec && (w_kind != KIND_LDI)) ? w_opcode : 8'h00;
            end

            if (w_ex_writes) begin
                r_wb_valid <= 1'b1;
                r_wb_rd    <= r_ex_rd;
                r_wb_data  <= w_ex_result;
            end

            // Flags are only defined by the ALU for ADD and CMP
            if (r_ex_vld && ((r_ex_kind == KIND_ADD) || (r_ex_kind == KIND_CMP))) begin
                r_flags <= alu_eflags[3:0];
            end
        end
    end

    assign alu_opcode = r_alu_opcode;
    assign alu_op1    = r_alu_op1;
    assign alu_op2    = r_alu_op2;
    assign flags      = r_flags;
    assign wb_valid   = r_wb_valid;
    assign wb_rd      = r_wb_rd;
    assign wb_data    = r_wb_data;
    assign illegal    = r_illegal;

endmodule : alu_issue_stage
`default_nettype wire
